// File: rtl/lr_demux.sv
// lr_demux: stereo matrix stage. Pops paired L+R / L-R samples from two
// first-word-fall-through FIFOs and writes left = sum + diff and
// right = sum - diff into two output FIFOs, one stereo pair per cycle.
//
// Optional build macro: LR_DEMUX_SATURATE_EN
//   defined   -> results clamp to the signed DATA_WIDTH range
//   undefined -> results wrap modulo 2^DATA_WIDTH
//
// Ports:
//   clock, reset                 clock; asynchronous active-low reset
//   sum_din/sum_empty/sum_rd_en  L+R FIFO head, empty flag, pop strobe
//   diff_din/diff_empty/diff_rd_en  L-R FIFO head, empty flag, pop strobe
//   left_dout/left_wr_en/left_full   left output FIFO interface
//   right_dout/right_wr_en/right_full  right output FIFO interface
//   sample_cnt                   stereo pairs written (wraps)
// Strobes are combinational from state and FIFO flags; data and count
// outputs are registered.
module lr_demux #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sum_din,
  input  logic                  sum_empty,
  output logic                  sum_rd_en,
  input  logic [DATA_WIDTH-1:0] diff_din,
  input  logic                  diff_empty,
  output logic                  diff_rd_en,
  output logic [DATA_WIDTH-1:0] left_dout,
  output logic                  left_wr_en,
  input  logic                  left_full,
  output logic [DATA_WIDTH-1:0] right_dout,
  output logic                  right_wr_en,
  input  logic                  right_full,
  output logic [CNT_WIDTH-1:0]  sample_cnt
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  can_read;
  logic                  can_write;
  logic                  pop_c;
  logic                  push_c;
  logic [DATA_WIDTH-1:0] left_res;
  logic [DATA_WIDTH-1:0] right_res;

  assign can_read  = !sum_empty && !diff_empty;
  assign can_write = !left_full && !right_full;

`ifdef LR_DEMUX_SATURATE_EN
  // One extra bit holds the exact result; differing top two bits mean overflow.
  localparam int unsigned EXT_W = DATA_WIDTH + 1;

  logic [EXT_W-1:0]      add_ext;
  logic [EXT_W-1:0]      sub_ext;
  logic [DATA_WIDTH-1:0] pos_max;
  logic [DATA_WIDTH-1:0] neg_max;

  assign pos_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  assign neg_max = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  assign add_ext = {sum_din[DATA_WIDTH-1], sum_din} + {diff_din[DATA_WIDTH-1], diff_din};
  assign sub_ext = {sum_din[DATA_WIDTH-1], sum_din} - {diff_din[DATA_WIDTH-1], diff_din};

  always_comb begin
    left_res  = add_ext[DATA_WIDTH-1:0];
    right_res = sub_ext[DATA_WIDTH-1:0];
    if (add_ext[EXT_W-1] != add_ext[EXT_W-2]) begin
      left_res = add_ext[EXT_W-1] ? neg_max : pos_max;
    end
    if (sub_ext[EXT_W-1] != sub_ext[EXT_W-2]) begin
      right_res = sub_ext[EXT_W-1] ? neg_max : pos_max;
    end
  end
`else
  assign left_res  = sum_din + diff_din;
  assign right_res = sum_din - diff_din;
`endif

  // Next-state, pop/write strobes and result loading; nothing moves in reset.
  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    cnt_d   = cnt_q;
    pop_c   = 1'b0;
    push_c  = 1'b0;

    if (reset) begin
      case (state_q)
        S_FETCH: begin
          if (can_read) begin
            pop_c   = 1'b1;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (can_write) begin
            push_c = 1'b1;
            cnt_d  = cnt_q + CNT_WIDTH'(1);
            if (can_read) begin
              pop_c = 1'b1;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = S_FETCH;
      endcase

      if (pop_c) begin
        left_d  = left_res;
        right_d = right_res;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      left_q  <= '0;
      right_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_rd_en   = pop_c;
  assign diff_rd_en  = pop_c;
  assign left_wr_en  = push_c;
  assign right_wr_en = push_c;
  assign left_dout   = left_q;
  assign right_dout  = right_q;
  assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_lr_demux.sv
module tb_lr_demux;

  logic        clock;
  logic        reset;
  logic [31:0] sum_din;
  logic        sum_empty;
  logic        sum_rd_en;
  logic [31:0] diff_din;
  logic        diff_empty;
  logic        diff_rd_en;
  logic [31:0] left_dout;
  logic        left_wr_en;
  logic        left_full;
  logic [31:0] right_dout;
  logic        right_wr_en;
  logic        right_full;
  logic [31:0] sample_cnt;

  lr_demux #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .sum_din(sum_din), .sum_empty(sum_empty), .sum_rd_en(sum_rd_en),
    .diff_din(diff_din), .diff_empty(diff_empty), .diff_rd_en(diff_rd_en),
    .left_dout(left_dout), .left_wr_en(left_wr_en), .left_full(left_full),
    .right_dout(right_dout), .right_wr_en(right_wr_en), .right_full(right_full),
    .sample_cnt(sample_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Source FIFO contents and forced-empty controls.
  logic [31:0] sum_q[$];
  logic [31:0] diff_q[$];
  logic        sum_hold;
  logic        diff_hold;

  // Reference model: an optional pending pair plus a write counter.
  logic        m_pend;
  logic [31:0] m_left, m_right, m_cnt;
  int          wr_seen, pop_seen;
  logic [31:0] wr_left_log[$];
  logic [31:0] wr_right_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fit(input longint v);
`ifdef LR_DEMUX_SATURATE_EN
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  // One clock cycle: present FIFO heads, compare against the model, advance.
  task automatic step();
    logic can_read, can_write, exp_pop, exp_wr;
    longint s, d;
    sum_empty  = (sum_q.size() == 0) || sum_hold;
    diff_empty = (diff_q.size() == 0) || diff_hold;
    sum_din    = sum_empty  ? 32'hDEAD_BEEF : sum_q[0];
    diff_din   = diff_empty ? 32'hBAAD_F00D : diff_q[0];
    if (!reset) begin
      m_pend = 1'b0; m_cnt = '0; m_left = '0; m_right = '0;
    end
    #1;
    can_read  = !sum_empty && !diff_empty;
    can_write = !left_full && !right_full;
    exp_pop   = reset && can_read && (!m_pend || can_write);
    exp_wr    = reset && m_pend && can_write;
    check("sum_rd_en",   64'(sum_rd_en),   64'(exp_pop));
    check("diff_rd_en",  64'(diff_rd_en),  64'(exp_pop));
    check("left_wr_en",  64'(left_wr_en),  64'(exp_wr));
    check("right_wr_en", 64'(right_wr_en), 64'(exp_wr));
    check("left_dout",   64'(left_dout),   64'(m_left));
    check("right_dout",  64'(right_dout),  64'(m_right));
    check("sample_cnt",  64'(sample_cnt),  64'(m_cnt));
    @(posedge clock);
    if (exp_wr) begin
      m_pend = 1'b0;
      m_cnt  = m_cnt + 32'd1;
      wr_seen++;
      wr_left_log.push_back(m_left);
      wr_right_log.push_back(m_right);
    end
    if (exp_pop) begin
      s = longint'($signed(sum_q[0]));
      d = longint'($signed(diff_q[0]));
      m_left  = fit(s + d);
      m_right = fit(s - d);
      m_pend  = 1'b1;
      void'(sum_q.pop_front());
      void'(diff_q.pop_front());
      pop_seen++;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sum_q.delete(); diff_q.delete();
    sum_hold = 1'b0; diff_hold = 1'b0;
    left_full = 1'b0; right_full = 1'b0;
    step(); step();
    reset = 1'b1;
    wr_seen = 0; pop_seen = 0;
    wr_left_log.delete(); wr_right_log.delete();
  endtask

  task automatic push_pair(input logic [31:0] s, input logic [31:0] d);
    sum_q.push_back(s);
    diff_q.push_back(d);
  endtask

  initial begin
    logic [31:0] first_left;
    reset = 1'b0;
    sum_hold = 1'b0; diff_hold = 1'b0;
    left_full = 1'b0; right_full = 1'b0;
    m_pend = 1'b0; m_left = '0; m_right = '0; m_cnt = '0;
    @(negedge clock);

    // Single pair.
    do_reset();
    push_pair(32'h0000_0400, 32'h0000_0100);
    for (int i = 0; i < 4; i++) step();
    check("single_writes", 64'(wr_seen), 64'd1);
    check("single_left",   64'(wr_left_log[0]),  64'h0000_0500);
    check("single_right",  64'(wr_right_log[0]), 64'h0000_0300);
    check("single_cnt",    64'(sample_cnt), 64'd1);

    // Overflow.
    do_reset();
    push_pair(32'h7FFF_FFFF, 32'h0000_0001);
    for (int i = 0; i < 3; i++) step();
`ifdef LR_DEMUX_SATURATE_EN
    check("ovf_left", 64'(wr_left_log[0]), 64'h7FFF_FFFF);
`else
    check("ovf_left", 64'(wr_left_log[0]), 64'h8000_0000);
`endif
    check("ovf_right", 64'(wr_right_log[0]), 64'h7FFF_FFFE);

    // Backpressure: held pair, left FIFO full for 5 cycles.
    do_reset();
    push_pair(32'h0000_1234, 32'h0000_0034);
    push_pair(32'h0000_0010, 32'h0000_0001);
    step();
    left_full = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("bp_no_writes", 64'(wr_seen),  64'd0);
    check("bp_one_pop",   64'(pop_seen), 64'd1);
    check("bp_hold_left", 64'(left_dout), 64'h0000_1268);
    left_full = 1'b0;
    step();
    check("bp_one_write", 64'(wr_seen), 64'd1);
    for (int i = 0; i < 3; i++) step();

    // Unbalanced input: diff FIFO empty for 10 cycles.
    do_reset();
    for (int i = 0; i < 3; i++) push_pair(32'(i * 7 + 1), 32'(i));
    diff_hold = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("unbal_no_pops", 64'(pop_seen), 64'd0);
    diff_hold = 1'b0;
    step();
    check("unbal_first_pop", 64'(pop_seen), 64'd1);
    for (int i = 0; i < 5; i++) step();
    check("unbal_cnt", 64'(sample_cnt), 64'd3);

    // Streaming: 100 preloaded pairs, writes on cycles 1..100.
    do_reset();
    for (int i = 0; i < 100; i++) push_pair($urandom(), $urandom());
    step();
    for (int i = 0; i < 100; i++) step();
    check("stream_writes", 64'(wr_seen), 64'd100);
    check("stream_cnt",    64'(sample_cnt), 64'd100);
    step();

    // Reset mid-stream while a pair is held.
    do_reset();
    for (int i = 0; i < 10; i++) push_pair(32'h100 * 32'(i), 32'(i));
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    step();
    check("mid_rst_cnt", 64'(sample_cnt), 64'd0);
    reset = 1'b1;
    wr_left_log.delete();
    for (int i = 0; i < 4; i++) step();
    first_left = wr_left_log[0];
    check("mid_rst_resume", 64'(first_left), 64'h0000_0303);

    // Random traffic with random stalls and extreme operands.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (sum_q.size() < 8 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: push_pair(32'h7FFF_FFFF - $urandom_range(0, 3), $urandom_range(0, 7));
          1: push_pair(32'h8000_0000 + $urandom_range(0, 3), 32'h8000_0000 + $urandom_range(0, 7));
          default: push_pair($urandom(), $urandom());
        endcase
      end
      sum_hold   = ($urandom_range(0, 7) == 0);
      diff_hold  = ($urandom_range(0, 7) == 0);
      left_full  = ($urandom_range(0, 5) == 0);
      right_full = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) reset = 1'b0;
      else reset = 1'b1;
      step();
    end
    reset = 1'b1;
    sum_hold = 1'b0; diff_hold = 1'b0;
    left_full = 1'b0; right_full = 1'b0;
    for (int i = 0; i < 20; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
